// File: rtl/shift_add_multiplier_if.sv
// Start/ready/valid handshake bundle for the multi-cycle MUL unit.
// The requester drives start/a/b; the multiplier returns status and product.
interface shift_add_multiplier_if #(
  parameter int N = 32
);
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         ready;
  logic         busy;
  logic         valid;
  logic [N-1:0] product;

  modport master (
    output start, a, b,
    input  ready, busy, valid, product
  );

  modport slave (
    input  start, a, b,
    output ready, busy, valid, product
  );
endinterface

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned N x N -> N multiplier: one multiplier bit per cycle,
// partial products formed by the combinational shift_left_logical stage.
module shift_left_logical (
  input  logic [31:0] in,
  input  logic [4:0]  shamt,
  output logic [31:0] out
);
  assign out = in << shamt;
endmodule

module shift_add_multiplier #(
  parameter int N = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  shift_add_multiplier_if.slave  bus
);
  localparam int CW = $clog2(N);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state_q,   state_d;
  logic [N-1:0]  a_reg_q,   a_reg_d;
  logic [N-1:0]  b_reg_q,   b_reg_d;
  logic [N-1:0]  acc_q,     acc_d;
  logic [CW-1:0] count_q,   count_d;
  logic [N-1:0]  product_q, product_d;

  logic [N-1:0]  shifted;
  logic [N-1:0]  acc_next;

  shift_left_logical u_sll (
    .in    (a_reg_q),
    .shamt (count_q),
    .out   (shifted)
  );

  // Carry out of the add is dropped: the product is modulo 2^N.
  assign acc_next = b_reg_q[count_q] ? (acc_q + shifted) : acc_q;

  always_comb begin
    state_d   = state_q;
    a_reg_d   = a_reg_q;
    b_reg_d   = b_reg_q;
    acc_d     = acc_q;
    count_d   = count_q;
    product_d = product_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_reg_d = bus.a;
          b_reg_d = bus.b;
          acc_d   = '0;
          count_d = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d   = acc_next;
        count_d = count_q + 1'b1;
        // The last bit's contribution must reach product on the same edge.
        if (count_q == CW'(N - 1)) begin
          product_d = acc_next;
          state_d   = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      a_reg_q   <= '0;
      b_reg_q   <= '0;
      acc_q     <= '0;
      count_q   <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      a_reg_q   <= a_reg_d;
      b_reg_q   <= b_reg_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      product_q <= product_d;
    end
  end

  // Outputs decode registered state only; nothing flows through from start/a/b.
  assign bus.ready   = (state_q == IDLE);
  assign bus.busy    = (state_q != IDLE);
  assign bus.valid   = (state_q == DONE);
  assign bus.product = product_q;
endmodule

// File: tb/tb_shift_add_multiplier.sv
// Scoreboard bench for shift_add_multiplier: expected products are queued when
// a multiply is issued and popped when the unit raises valid.
module tb_shift_add_multiplier;
  localparam int N = 32;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  logic [N-1:0] exp_q[$];

  shift_add_multiplier_if #(.N(N)) bus ();

  shift_add_multiplier #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive start for one accepting edge; returns at the negedge after E0.
  task automatic issue(input logic [N-1:0] x, input logic [N-1:0] y, input bit push);
    bus.a     = x;
    bus.b     = y;
    bus.start = 1'b1;
    if (push) exp_q.push_back(x * y);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (bus.valid !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic pop_check(input string name);
    logic [N-1:0] e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: product=%h with empty scoreboard", name, bus.product);
    end else begin
      e = exp_q.pop_front();
      if (bus.product !== e) begin
        n_fail++;
        $display("FAIL %s: product=%h expected=%h", name, bus.product, e);
      end
    end
  endtask

  task automatic do_mul(input logic [N-1:0] x, input logic [N-1:0] y, input string name);
    int cyc;
    issue(x, y, 1'b1);
    wait_valid(cyc);
    n_checks++;
    if (cyc !== N) begin
      n_fail++;
      $display("FAIL %s_latency: got %0d expected %0d", name, cyc, N);
    end
    pop_check(name);
    @(negedge clk);
    n_checks++;
    if (bus.valid !== 1'b0 || bus.ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_after: valid=%b ready=%b expected valid=0 ready=1", name, bus.valid, bus.ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.ready !== 1'b1 || bus.busy !== 1'b0 || bus.valid !== 1'b0 || bus.product !== '0) begin
      n_fail++;
      $display("FAIL reset: ready=%b busy=%b valid=%b product=%h expected 1 0 0 0",
               bus.ready, bus.busy, bus.valid, bus.product);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int cyc;
    int rlow;
    issue(32'd3, 32'd5, 1'b1);
    n_checks++;
    if (bus.ready !== 1'b0 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_accept: ready=%b busy=%b expected 0 1", bus.ready, bus.busy);
    end
    cyc = 0;
    rlow = 0;
    while (bus.valid !== 1'b1 && cyc < 200) begin
      if (bus.ready === 1'b0) rlow++;
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (cyc !== N) begin
      n_fail++;
      $display("FAIL basic_latency: got %0d expected %0d", cyc, N);
    end
    pop_check("basic");
    while (bus.ready !== 1'b1 && cyc < 200) begin
      rlow++;
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (rlow !== N + 1) begin
      n_fail++;
      $display("FAIL basic_ready_low: got %0d cycles expected %0d", rlow, N + 1);
    end
    n_checks++;
    if (bus.valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_valid_pulse: valid=%b expected 0", bus.valid);
    end
  endtask

  task automatic test_wrap();
    do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, "wrap_ones");
    do_mul(32'h0001_0000, 32'h0001_0000, "wrap_zero");
  endtask

  task automatic test_msb_zero();
    do_mul(32'h0000_0001, 32'h8000_0000, "msb");
    do_mul(32'h1234_5678, 32'h0000_0000, "b_zero");
    do_mul(32'hDEAD_BEEF, 32'h0000_0003, "mixed");
  endtask

  task automatic test_ignored_start();
    int cyc;
    int extra;
    issue(32'd7, 32'd6, 1'b1);
    repeat (5) @(negedge clk);
    bus.a = 32'd9;
    bus.b = 32'd9;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_valid(cyc);
    pop_check("ignored_start");
    // Pulse start again while DONE is showing.
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    extra = 0;
    repeat (40) begin
      if (bus.valid === 1'b1 || bus.ready !== 1'b1) extra++;
      @(negedge clk);
    end
    n_checks++;
    if (extra !== 0) begin
      n_fail++;
      $display("FAIL ignored_no_second_op: %0d busy/valid cycles expected 0", extra);
    end
  endtask

  task automatic test_reset_mid();
    int extra;
    issue(32'd100, 32'd100, 1'b0);
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (bus.ready !== 1'b1 || bus.busy !== 1'b0 || bus.valid !== 1'b0 || bus.product !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: ready=%b busy=%b valid=%b product=%h expected 1 0 0 0",
               bus.ready, bus.busy, bus.valid, bus.product);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    extra = 0;
    repeat (40) begin
      if (bus.valid === 1'b1) extra++;
      @(negedge clk);
    end
    n_checks++;
    if (extra !== 0) begin
      n_fail++;
      $display("FAIL reset_mid_no_valid: %0d valid cycles expected 0", extra);
    end
    do_mul(32'd12, 32'd12, "after_reset");
  endtask

  task automatic test_back_to_back();
    int cyc;
    int gap;
    int held_bad;
    bus.a = 32'd2;
    bus.b = 32'd3;
    bus.start = 1'b1;
    exp_q.push_back(32'd6);
    exp_q.push_back(32'd20);
    @(negedge clk);
    wait_valid(cyc);
    pop_check("b2b_first");
    bus.a = 32'd4;
    bus.b = 32'd5;
    gap = 0;
    held_bad = 0;
    @(negedge clk);
    gap++;
    while (bus.valid !== 1'b1 && gap < 200) begin
      if (bus.product !== 32'd6) held_bad++;
      @(negedge clk);
      gap++;
    end
    bus.start = 1'b0;
    n_checks++;
    if (gap !== N + 2) begin
      n_fail++;
      $display("FAIL b2b_spacing: got %0d expected %0d", gap, N + 2);
    end
    n_checks++;
    if (held_bad !== 0) begin
      n_fail++;
      $display("FAIL b2b_hold: product changed in %0d cycles expected 0", held_bad);
    end
    pop_check("b2b_second");
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_idle: ready=%b expected 1", bus.ready);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    test_reset();
    test_basic();
    test_wrap();
    test_msb_zero();
    test_ignored_start();
    test_reset_mid();
    test_back_to_back();
    n_checks++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
